// File: rtl/sw_report_ctrl.sv
// sw_report_ctrl: arbitrates manual and periodic report requests and streams
// each granted request as a 4-byte ASCII frame to a UART TX byte interface.
module sw_report_ctrl #(
    parameter int          CLK_FREQ_HZ      = 100_000_000,
    parameter logic [15:0] REPORT_PERIOD_MS = 16'd500
) (
    input  logic       clk_core,
    input  logic       rst,
    input  logic [3:0] sw_filt,
    input  logic [1:0] btn_filt,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       auto_en,
    output logic       busy,
    output logic [7:0] frame_cnt
);
    localparam logic [31:0] PRE_MAX = 32'(CLK_FREQ_HZ / 1000 - 1);
    localparam logic [15:0] MS_MAX  = REPORT_PERIOD_MS - 16'd1;
    localparam logic [0:0]  IDLE    = 1'b0;
    localparam logic [0:0]  SEND    = 1'b1;

    logic [0:0]  state;
    logic [1:0]  btn_q, press, idx;
    logic [31:0] pre_cnt;
    logic [15:0] ms_cnt;
    logic [3:0]  snap;
    logic [7:0]  hex_char;
    logic        man_pend, per_pend, kind, expiry, grant_man, grant_per, hs;

    assign press     = btn_filt & ~btn_q;
    assign expiry    = auto_en && pre_cnt == PRE_MAX && ms_cnt == MS_MAX;
    assign grant_man = state == IDLE && man_pend;
    assign grant_per = state == IDLE && !man_pend && per_pend;
    assign hs        = state == SEND && tx_ready;
    assign hex_char  = snap < 4'd10 ? 8'h30 + {4'h0, snap} : 8'h37 + {4'h0, snap};
    assign tx_valid  = state == SEND;
    assign busy      = tx_valid;
    // kind=1 marks an auto-report frame
    assign tx_data   = !tx_valid    ? 8'h00 :
                       idx == 2'd0  ? (kind ? 8'h41 : 8'h4D) :
                       idx == 2'd1  ? hex_char :
                       idx == 2'd2  ? 8'h0D : 8'h0A;

    always_ff @(posedge clk_core) begin
        if (rst) begin
            btn_q     <= 2'b11;
            auto_en   <= 1'b0;
            pre_cnt   <= '0;
            ms_cnt    <= '0;
            man_pend  <= 1'b0;
            per_pend  <= 1'b0;
            state     <= IDLE;
            idx       <= 2'd0;
            kind      <= 1'b0;
            snap      <= 4'h0;
            frame_cnt <= 8'h00;
        end else begin
            btn_q    <= btn_filt;
            auto_en  <= auto_en ^ press[1];
            man_pend <= press[0] | (man_pend & ~grant_man);
            per_pend <= expiry | (per_pend & ~grant_per & ~(press[1] & auto_en));
            // timer is frozen at zero whenever auto mode is off or being toggled
            if (!auto_en || press[1] || expiry) begin
                pre_cnt <= '0;
                ms_cnt  <= '0;
            end else if (pre_cnt == PRE_MAX) begin
                pre_cnt <= '0;
                ms_cnt  <= ms_cnt + 16'd1;
            end else begin
                pre_cnt <= pre_cnt + 32'd1;
            end
            if (grant_man || grant_per) begin
                state <= SEND;
                kind  <= grant_per;
                snap  <= sw_filt;
                idx   <= 2'd0;
            end else if (hs) begin
                idx <= idx + 2'd1;
                if (idx == 2'd3) begin
                    state     <= IDLE;
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
        end
    end
endmodule

// File: doc/sw_report_ctrl.md
# sw_report_ctrl

Controller that turns debounced user-input events into UART transmit traffic. It sits between the input conditioning stage (synchronized, debounced `sw_filt[3:0]` / `btn_filt[1:0]`) and the UART TX byte interface. It arbitrates between two requesters, a manual button press and a periodic auto-report timer, and sequences each granted request as a 4-byte ASCII report frame over a valid/ready handshake.

## Interface
- `CLK_FREQ_HZ`, default 100_000_000: clk_core frequency. One ms tick every CLK_FREQ_HZ/1000 cycles.
- `REPORT_PERIOD_MS`, default 16'd500: auto-report period in ms. Must be ≥ 1.

- `clk_core` in 1: single clock for all logic.
- `rst` in 1: synchronous, active-high reset.
- `sw_filt` in 4: debounced switches, value reported in frames.
- `btn_filt` in 2: debounced buttons. [0] requests a manual report; [1] toggles auto mode.
- `tx_data` out 8: byte to UART TX.
- `tx_valid` out 1: tx_data valid.
- `tx_ready` in 1: UART TX accepts byte when `tx_valid & tx_ready`.
- `auto_en` out 1: auto-report mode active.
- `busy` out 1: frame in progress (state ≠ IDLE).
- `frame_cnt` out 8: completed frames, wraps 255→0.

## Operation
- Reset values: tx_valid=0, tx_data=8'h00, auto_en=0, busy=0, frame_cnt=0, both pending flags=0, timers=0, state=IDLE, btn_q=2'b11.
- Edge detect: press[i] = btn_filt[i] & ~btn_q[i]; btn_q <= btn_filt each cycle. btn_q resets to 2'b11, so a button held through reset fires only after release and re-press.
- press[1]: toggle auto_en. On 0→1, prescaler and ms counter clear. On 1→0, per_pend clears; an in-flight auto frame completes.
- Timer, active only when auto_en=1 (held at 0 otherwise): prescaler counts 0..CLK_FREQ_HZ/1000-1; ms_cnt increments at prescaler terminal, range 0..REPORT_PERIOD_MS-1. Expiry = both at terminal; sets per_pend and wraps both to 0.
- Pending flags: man_pend set by press[0]; per_pend set by expiry. Each is single-depth: repeat events while set coalesce. If a set and a clear of the same flag coincide, the set wins.
- FSM:
  - IDLE: if man_pend (priority) or per_pend, go to SEND. In that same cycle, clear only the granted flag, latch kind (manual/auto), snapshot sw_filt, and set idx=0.
  - SEND: tx_valid=1, tx_data=frame[idx]. On handshake: if idx==3, go to IDLE and increment frame_cnt; else idx++.
- Frame bytes, in order:
  - Marker: 0x4D 'M' for manual, 0x41 'A' for auto.
  - Hex char of the snapshot: 0–9 → 0x30+n; A–F → 0x41+(n-10).
  - 0x0D.
  - 0x0A.
- sw_filt changes mid-frame do not affect the frame in progress.
- tx_data holds 8'h00 whenever tx_valid=0.

## Timing
- btn_filt[0] rises before edge k: man_pend=1 after edge k. Frame starts at edge k+1; tx_valid=1 with the marker byte from then on.
- With tx_ready held high, the 4 bytes go out on 4 consecutive cycles. busy falls and frame_cnt increments after the 4th handshake edge.
- Minimum one IDLE cycle between frames.
- tx_valid never depends combinationally on tx_ready. Once asserted, tx_valid stays high and tx_data stays stable until the handshake.
- First auto frame request: per_pend sets REPORT_PERIOD_MS·CLK_FREQ_HZ/1000 cycles after auto_en rises, then repeats at that period.
- rst mid-frame: all state returns to reset values at the next edge, tx_valid=0, and the partial frame is abandoned with no resume.

## Test plan
Bench parameters: CLK_FREQ_HZ=10_000 (10 cycles/ms), REPORT_PERIOD_MS=3 (30-cycle period).

1. Hold btn_filt[0]=1 through rst release → no tx_valid for 50 cycles. Then release and re-press → one 'M' frame.
2. sw_filt=4'hB, press btn0, tx_ready=1 → tx_data sequence 0x4D, 0x42, 0x0D, 0x0A on 4 consecutive cycles, starting 2 cycles after the press; frame_cnt=1, busy=0 afterward.
3. tx_ready=0 for 5 cycles during byte 1; change sw_filt to 4'h2 mid-frame → tx_data held at 0x42 with tx_valid high throughout; frame completes with 0x0D, 0x0A.
4. sw_filt=4'h3, press btn1 → auto_en=1; 'A' frames (0x41, 0x33, 0x0D, 0x0A) with per_pend set every 30 cycles, first 30 cycles after auto_en rises. Press btn1 again → auto_en=0 and no further 'A' frames.
5. Hold tx_ready=0 in auto mode, press btn0 during an 'A' frame and let one period expire → after release, the 'A' frame completes, then the 'M' frame is sent before the next 'A' frame; extra presses coalesce into one 'M' frame.
6. Assert rst after the 2nd byte handshake → tx_valid=0, frame_cnt=0, auto_en=0 at the next edge; separately, send 256 frames → frame_cnt wraps to 0.
